// File: rtl/gs_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches ahead of the IF stage,
// tracks in-flight requests and queues returned words with their addresses.
// A redirect empties the queue and drops every response still in flight.
module gs_prefetch_buffer #(
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          WORD_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] BOOT_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boot_i,
  input  logic                 flush_i,
  input  logic [ADDR_SIZE-1:0] flush_addr_i,
  output logic                 instr_req_o,
  output logic [ADDR_SIZE-1:0] instr_addr_o,
  input  logic                 instr_gnt_i,
  input  logic                 instr_rvalid_i,
  input  logic [WORD_SIZE-1:0] instr_rdata_i,
  output logic                 fetch_valid_o,
  input  logic                 fetch_ready_i,
  output logic [WORD_SIZE-1:0] fetch_instr_o,
  output logic [ADDR_SIZE-1:0] fetch_addr_o,
  output logic                 busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [CW:0]          CREDIT_MAX = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]        FULL       = CW'(DEPTH);
  localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
  localparam logic [PW-1:0]        PTR_ONE    = PW'(1);
  localparam logic [ADDR_SIZE-1:0] WORD_STEP  = ADDR_SIZE'(4);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = {{(ADDR_SIZE-2){1'b1}}, 2'b00};

  typedef enum logic {StIdle, StFetch} state_e;

  state_e               state;
  logic [ADDR_SIZE-1:0] next_addr;
  logic [ADDR_SIZE-1:0] resp_addr;
  logic [WORD_SIZE-1:0] data_mem [DEPTH];
  logic [ADDR_SIZE-1:0] addr_mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_count, outstanding, discard;

  logic                 req, fire, push, pop;
  logic [CW:0]          credit_used;
  logic [CW-1:0]        outstanding_next;
  logic [ADDR_SIZE-1:0] flush_target;

  // Credit check, handshake qualifiers and next outstanding count
  always_comb begin
    credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
    req              = (state == StFetch) && (credit_used < CREDIT_MAX) && !flush_i;
    fire             = req && instr_gnt_i;
    push             = instr_rvalid_i && (discard == '0) && !flush_i;
    pop              = (fifo_count != '0) && fetch_ready_i && !flush_i;
    outstanding_next = outstanding + {{(CW-1){1'b0}}, fire}
                                   - {{(CW-1){1'b0}}, instr_rvalid_i};
    flush_target     = flush_addr_i & ALIGN_MASK;
  end

  assign instr_req_o   = req;
  assign instr_addr_o  = next_addr;
  assign fetch_valid_o = (fifo_count != '0);
  assign fetch_instr_o = data_mem[rd_ptr];
  assign fetch_addr_o  = addr_mem[rd_ptr];
  assign busy_o        = (state == StFetch) || (outstanding != '0);

  // FSM, fetch/response address tracking and in-flight bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      next_addr   <= '0;
      resp_addr   <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (flush_i) begin
        // Everything still in flight after this cycle belongs to the old stream.
        state     <= StFetch;
        next_addr <= flush_target;
        resp_addr <= flush_target;
        discard   <= outstanding_next;
      end else begin
        if ((state == StIdle) && boot_i) begin
          state     <= StFetch;
          next_addr <= BOOT_ADDR;
          resp_addr <= BOOT_ADDR;
        end else if (fire) begin
          next_addr <= next_addr + WORD_STEP;
        end
        if (instr_rvalid_i) begin
          if (discard != '0) begin
            discard <= discard - CNT_ONE;
          end else begin
            resp_addr <= resp_addr + WORD_STEP;
          end
        end
      end
    end
  end

  // In-order word queue; a redirect empties it and voids a same-cycle pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= instr_rdata_i;
        addr_mem[wr_ptr] <= resp_addr;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_ONE;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CNT_ONE;
      end
    end
  end

  // The credit rule must never let a response land in a full queue
  assert property (@(posedge clk) disable iff (!rst) !(push && (fifo_count == FULL)));

endmodule

// File: tb/tb_gs_prefetch_buffer.sv
// Bench for gs_prefetch_buffer: a directed vector table, hand-written corner sequences
// and randomized traffic checked against a request-level reference model.
module tb_gs_prefetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        boot_i = 1'b0, flush_i = 1'b0;
  logic [31:0] flush_addr_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_instr_o, fetch_addr_o;
  logic        busy_o;

  gs_prefetch_buffer #(.DEPTH(DEPTH), .ADDR_SIZE(32), .WORD_SIZE(32), .BOOT_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .boot_i(boot_i), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_instr_o(fetch_instr_o), .fetch_addr_o(fetch_addr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: requests in flight (killed by a redirect) and the queue of returned words
  typedef struct packed {logic [31:0] addr; logic live;} req_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] data;} ent_t;
  req_t        inflight[$];
  ent_t        fifo[$];
  logic [31:0] m_next = '0;
  bit          m_fetch = 1'b0;

  // Last sampled outputs and grant counter for directed checks
  logic        s_req, s_valid, s_busy;
  logic [31:0] s_addr, s_faddr;
  int          grants = 0;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // One cycle: drive at negedge, compare against the model, then advance the model
  task automatic step(input bit b, input bit f, input logic [31:0] fa, input bit g,
                      input bit rv, input bit rd);
    bit   e_req, fire;
    req_t r;
    ent_t e;
    @(negedge clk);
    boot_i         = b;
    flush_i        = f;
    flush_addr_i   = fa;
    instr_gnt_i    = g;
    instr_rvalid_i = rv && (inflight.size() > 0);
    instr_rdata_i  = instr_rvalid_i ? dat(inflight[0].addr) : $urandom;
    fetch_ready_i  = rd;
    #1;
    s_req = instr_req_o; s_addr = instr_addr_o; s_valid = fetch_valid_o;
    s_faddr = fetch_addr_o; s_busy = busy_o;
    if (instr_req_o && g) grants++;
    e_req = m_fetch && ((fifo.size() + inflight.size()) < DEPTH) && !f;
    chk("req", instr_req_o, e_req);
    chk("addr", instr_addr_o, m_next);
    chk("valid", fetch_valid_o, fifo.size() != 0);
    if (fifo.size() != 0) begin
      chk("fetch_addr", fetch_addr_o, fifo[0].addr);
      chk("fetch_instr", fetch_instr_o, fifo[0].data);
    end
    chk("busy", busy_o, m_fetch || (inflight.size() != 0));
    fire = e_req && g;
    if ((fifo.size() != 0) && rd && !f) void'(fifo.pop_front());
    if (instr_rvalid_i) begin
      r = inflight.pop_front();
      if (r.live && !f) begin
        e.addr = r.addr;
        e.data = dat(r.addr);
        fifo.push_back(e);
      end
    end
    if (f) begin
      fifo.delete();
      foreach (inflight[i]) inflight[i].live = 1'b0;
      m_next  = fa & 32'hFFFF_FFFC;
      m_fetch = 1'b1;
    end else if (!m_fetch && b) begin
      m_fetch = 1'b1;
      m_next  = 32'h0;
    end
    if (fire) begin
      r.addr = m_next;
      r.live = 1'b1;
      inflight.push_back(r);
      m_next = m_next + 32'd4;
    end
  endtask

  // Asynchronous reset mid-cycle: outputs must clear at once, no clock edge needed
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    boot_i = 1'b0; flush_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    fetch_ready_i = 1'b0;
    #1;
    chk("rst_req", instr_req_o, 1'b0);
    chk("rst_valid", fetch_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_addr", instr_addr_o, 32'h0);
    chk("rst_faddr", fetch_addr_o, 32'h0);
    chk("rst_instr", fetch_instr_o, 32'h0);
    inflight.delete();
    fifo.delete();
    m_next  = '0;
    m_fetch = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic b, f; logic [31:0] fa; logic g, rv, rd; logic [31:0] rdata;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_faddr, e_instr;
    logic e_busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Boot, full-rate grants, responses one cycle later
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0,     0, 32'h0,  0, 0,     0,     0};
    tbl[1] = '{0, 0, 0, 1, 0, 0, 0,     1, 32'h0,  0, 0,     0,     1};
    tbl[2] = '{0, 0, 0, 1, 1, 0, 'hA0,  1, 32'h4,  0, 0,     0,     1};
    tbl[3] = '{0, 0, 0, 1, 1, 1, 'hA1,  1, 32'h8,  1, 32'h0, 'hA0,  1};
    tbl[4] = '{0, 0, 0, 0, 1, 1, 'hA2,  1, 32'hC,  1, 32'h4, 'hA1,  1};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 0,     1, 32'hC,  1, 32'h8, 'hA2,  1};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0,     1, 32'hC,  0, 0,     0,     1};
    tbl[7] = '{0, 0, 0, 1, 0, 0, 0,     1, 32'hC,  0, 0,     0,     1};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0,     1, 32'h10, 0, 0,     0,     1};

    #3;
    chk("por_req", instr_req_o, 1'b0);
    chk("por_valid", fetch_valid_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      boot_i = tbl[i].b; flush_i = tbl[i].f; flush_addr_i = tbl[i].fa;
      instr_gnt_i = tbl[i].g; instr_rvalid_i = tbl[i].rv; instr_rdata_i = tbl[i].rdata;
      fetch_ready_i = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_req", i), instr_req_o, tbl[i].e_req);
      chk($sformatf("tbl%0d_addr", i), instr_addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), fetch_valid_o, tbl[i].e_valid);
      chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_faddr", i), fetch_addr_o, tbl[i].e_faddr);
        chk($sformatf("tbl%0d_finstr", i), fetch_instr_o, tbl[i].e_instr);
      end
    end

    // Credit limit: ready low, exactly DEPTH grants; one pop frees exactly one request
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    grants = 0;
    repeat (10) step(0, 0, 0, 1, 1, 0);
    chk("fill_grants", grants, DEPTH);
    chk("fill_req_off", s_req, 1'b0);
    grants = 0;
    step(0, 0, 0, 1, 1, 1);
    repeat (6) step(0, 0, 0, 1, 1, 0);
    chk("fill_regrant", grants, 1);

    // Grant stall: request and address hold, then advance by one word
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    repeat (3) begin
      step(0, 0, 0, 0, 0, 0);
      chk("stall_req", s_req, 1'b1);
      chk("stall_addr", s_addr, 32'h0);
    end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("stall_adv", s_addr, 32'h4);

    // Redirect with two requests in flight; target low bits ignored
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h103, 1, 0, 1);
    chk("flush_req_off", s_req, 1'b0);
    step(0, 0, 0, 0, 1, 1);
    chk("flush_empty", s_valid, 1'b0);
    chk("flush_next", s_addr, 32'h100);
    step(0, 0, 0, 0, 1, 1);
    chk("flush_drop", s_valid, 1'b0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        step(0, 0, 0, 1, 1, 0);
        if (s_valid) begin
          seen = 1'b1;
          chk("flush_first", s_faddr, 32'h100);
        end
      end
      chk("flush_seen", seen, 1'b1);
    end

    // Response in the redirect cycle is dropped along with the remaining two
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h200, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rvflush_empty", s_valid, 1'b0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        step(0, 0, 0, 1, 1, 0);
        if (s_valid) begin
          seen = 1'b1;
          chk("rvflush_first", s_faddr, 32'h200);
        end
      end
      chk("rvflush_seen", seen, 1'b1);
    end

    // Address wrap at the top of the space
    do_reset();
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("wrap_top", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_zero", s_addr, 32'h0);

    // Reset with two words buffered, then stay idle until boot
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && fifo.size() < 2; k++) step(0, 0, 0, 1, 1, 0);
    chk("mid_buffered", fifo.size(), 2);
    do_reset();
    repeat (3) begin
      step(0, 0, 0, 1, 1, 1);
      chk("idle_req", s_req, 1'b0);
      chk("idle_busy", s_busy, 1'b0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
